// File: rtl/cardinal_nic_pkg.sv
// Shared definitions for the cardinal NIC.
// Contents:
//   - PE register address map.
//   - Default flit width and VC bit position.
//   - Header field offsets within a flit.
//   - A small header decode helper.
package cardinal_nic_pkg;

    localparam int FLIT_W = 64;
    localparam int VC_BIT = FLIT_W - 1;

    // PE register address map
    localparam logic [1:0] ADDR_IN_DATA  = 2'b00;
    localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] ADDR_OUT_DATA = 2'b10;
    localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

    // Header field offsets
    localparam int DX_BIT    = 62;
    localparam int DY_BIT    = 61;
    localparam int HX_MSB    = 55;
    localparam int HX_LSB    = 52;
    localparam int HY_MSB    = 51;
    localparam int HY_LSB    = 48;
    localparam int SRCX_MSB  = 47;
    localparam int SRCX_LSB  = 40;
    localparam int SRCY_MSB  = 39;
    localparam int SRCY_LSB  = 32;

    typedef struct packed {
        logic       vc;
        logic       dx;
        logic       dy;
        logic [3:0] hx;
        logic [3:0] hy;
        logic [7:0] src_x;
        logic [7:0] src_y;
    } flit_hdr_t;

    function automatic flit_hdr_t decode_hdr(input logic [FLIT_W-1:0] flit);
        flit_hdr_t h;
        h.vc    = flit[VC_BIT];
        h.dx    = flit[DX_BIT];
        h.dy    = flit[DY_BIT];
        h.hx    = flit[HX_MSB:HX_LSB];
        h.hy    = flit[HY_MSB:HY_LSB];
        h.src_x = flit[SRCX_MSB:SRCX_LSB];
        h.src_y = flit[SRCY_MSB:SRCY_LSB];
        return h;
    endfunction

endpackage

// File: rtl/cardinal_nic_chan_buf.sv
// One-entry channel buffer: a data register plus a full flag.
// Ports:
//   clk, reset (async, active-low)
//   load   - capture d_in and set full; ignored while already full
//   unload - clear full; the stored data is retained
//   d_in   - data to capture
//   data   - stored data
//   full   - buffer occupancy
module nic_chan_buf #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              unload,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] data,
    output logic              full
);

    // Occupancy is sampled before the edge: a load while full is dropped
    // even if an unload happens on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full <= 1'b0;
            data <= '0;
        end else begin
            if (load && !full) begin
                data <= d_in;
                full <= 1'b1;
            end else if (unload) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cardinal_nic.sv
// Network interface controller between one PE and its cardinal router port.
// Ports:
//   clk, reset (async, active-low)
//   addr, d_in, nicEn, nicEnWr - PE register access
//   d_out                      - registered PE read data
//   net_so, net_ri, net_do     - outbound flit handshake to router
//   net_si, net_ro, net_di     - inbound flit handshake from router
//   net_polarity               - router phase; gates outbound VC
module cardinal_nic
    import cardinal_nic_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    input  logic              nicEn,
    input  logic              nicEnWr,
    output logic              net_so,
    input  logic              net_ri,
    output logic [DATA_W-1:0] net_do,
    input  logic              net_si,
    output logic              net_ro,
    input  logic [DATA_W-1:0] net_di,
    input  logic              net_polarity
);

    logic [DATA_W-1:0] in_data;
    logic              in_full;
    logic [DATA_W-1:0] out_data;
    logic              out_full;

    logic              rd_en;
    logic [DATA_W-1:0] rd_val;
    logic              in_unload;
    logic              out_load;
    logic              in_load;

    assign out_load  = nicEn && nicEnWr && (addr == ADDR_OUT_DATA);
    assign in_load   = net_si && net_ro;
    assign in_unload = nicEn && !nicEnWr && (addr == ADDR_IN_DATA);

    // A flit only leaves when its VC bit matches the router phase.
    assign net_so = out_full && net_ri && (out_data[DATA_W-1] == net_polarity);
    assign net_do = out_data;
    assign net_ro = !in_full;

    nic_chan_buf #(.DATA_W(DATA_W)) u_out_buf (
        .clk    (clk),
        .reset  (reset),
        .load   (out_load),
        .unload (net_so),
        .d_in   (d_in),
        .data   (out_data),
        .full   (out_full)
    );

    nic_chan_buf #(.DATA_W(DATA_W)) u_in_buf (
        .clk    (clk),
        .reset  (reset),
        .load   (in_load),
        .unload (in_unload),
        .d_in   (net_di),
        .data   (in_data),
        .full   (in_full)
    );

    always_comb begin
        rd_en  = 1'b0;
        rd_val = '0;
        if (nicEn && !nicEnWr) begin
            case (addr)
                ADDR_IN_DATA: begin
                    rd_en  = 1'b1;
                    rd_val = in_data;
                end
                ADDR_IN_STAT: begin
                    rd_en  = 1'b1;
                    rd_val = {{(DATA_W-1){1'b0}}, in_full};
                end
                ADDR_OUT_STAT: begin
                    rd_en  = 1'b1;
                    rd_val = {{(DATA_W-1){1'b0}}, out_full};
                end
                default: begin
                    rd_en  = 1'b0;
                    rd_val = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_out <= '0;
        end else if (rd_en) begin
            d_out <= rd_val;
        end
    end

endmodule

// File: tb/tb_cardinal_nic.sv
module tb_cardinal_nic;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  addr = 2'b00;
    logic [63:0] d_in = '0;
    logic [63:0] d_out;
    logic        nicEn = 1'b0;
    logic        nicEnWr = 1'b0;
    logic        net_so;
    logic        net_ri = 1'b0;
    logic [63:0] net_do;
    logic        net_si = 1'b0;
    logic        net_ro;
    logic [63:0] net_di = '0;
    logic        net_polarity = 1'b0;

    int compared = 0;
    int mismatched = 0;

    cardinal_nic #(.DATA_W(64), .ADDR_W(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicEnWr      (nicEnWr),
        .net_so       (net_so),
        .net_ri       (net_ri),
        .net_do       (net_do),
        .net_si       (net_si),
        .net_ro       (net_ro),
        .net_di       (net_di),
        .net_polarity (net_polarity)
    );

    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pe_write(input logic [1:0] a, input logic [63:0] v);
        addr = a; d_in = v; nicEn = 1'b1; nicEnWr = 1'b1;
        tick();
        nicEn = 1'b0; nicEnWr = 1'b0;
    endtask

    task automatic pe_read(input logic [1:0] a);
        addr = a; nicEn = 1'b1; nicEnWr = 1'b0;
        tick();
        nicEn = 1'b0;
    endtask

    task automatic rx_flit(input logic [63:0] v);
        net_si = 1'b1; net_di = v;
        tick();
        net_si = 1'b0;
    endtask

    initial begin
        // Initial reset
        #2 reset = 1'b0;
        #1;
        check("rst_d_out", d_out, 64'h0);
        check("rst_net_so", {63'h0, net_so}, 64'h0);
        check("rst_net_ro", {63'h0, net_ro}, 64'h1);
        check("rst_net_do", net_do, 64'h0);
        @(negedge clk) reset = 1'b1;
        tick();
        pe_read(2'b01);
        check("rst_in_stat", d_out, 64'h0);
        pe_read(2'b11);
        check("rst_out_stat", d_out, 64'h0);

        // Send with matching polarity
        net_ri = 1'b1; net_polarity = 1'b0;
        pe_write(2'b10, 64'h2033_0300_DEADBEEF);
        check("send_so", {63'h0, net_so}, 64'h1);
        check("send_do", net_do, 64'h2033_0300_DEADBEEF);
        tick();
        check("send_so_after", {63'h0, net_so}, 64'h0);
        pe_read(2'b11);
        check("send_out_stat", d_out, 64'h0);

        // VC bit mismatches polarity: flit waits
        pe_write(2'b10, 64'h8000_0000_0000_0011);
        check("hold_so_c0", {63'h0, net_so}, 64'h0);
        tick();
        check("hold_so_c1", {63'h0, net_so}, 64'h0);
        tick();
        check("hold_so_c2", {63'h0, net_so}, 64'h0);
        net_polarity = 1'b1;
        #1;
        check("hold_so_toggle", {63'h0, net_so}, 64'h1);
        check("hold_do", net_do, 64'h8000_0000_0000_0011);
        tick();
        check("hold_so_after", {63'h0, net_so}, 64'h0);
        net_polarity = 1'b0;
        pe_read(2'b11);
        check("hold_out_stat", d_out, 64'h0);

        // Overflow: B dropped while A waits for net_ri
        net_ri = 1'b0;
        pe_write(2'b10, 64'h0000_0000_0000_00AA);
        pe_write(2'b10, 64'h0000_0000_0000_00BB);
        pe_read(2'b11);
        check("ovf_out_stat", d_out, 64'h1);
        net_ri = 1'b1;
        #1;
        check("ovf_so", {63'h0, net_so}, 64'h1);
        check("ovf_do_a", net_do, 64'h0000_0000_0000_00AA);
        tick();
        check("ovf_so_after", {63'h0, net_so}, 64'h0);
        pe_read(2'b11);
        check("ovf_out_stat_empty", d_out, 64'h0);

        // Write on the same edge as a completing send is dropped
        pe_write(2'b10, 64'h0000_0000_0000_0C01);
        pe_write(2'b10, 64'h0000_0000_0000_0C02);
        check("wsend_so", {63'h0, net_so}, 64'h0);
        check("wsend_do", net_do, 64'h0000_0000_0000_0C01);
        pe_read(2'b11);
        check("wsend_out_stat", d_out, 64'h0);

        // Receive
        rx_flit(64'hA000_0000_CAFEF00D);
        check("rx_ro_full", {63'h0, net_ro}, 64'h0);
        pe_read(2'b01);
        check("rx_in_stat", d_out, 64'h1);
        pe_read(2'b00);
        check("rx_data", d_out, 64'hA000_0000_CAFEF00D);
        check("rx_ro_after", {63'h0, net_ro}, 64'h1);
        pe_read(2'b01);
        check("rx_in_stat_empty", d_out, 64'h0);
        tick();
        check("rx_d_out_hold", d_out, 64'h0);
        pe_read(2'b10);
        check("rx_rd10_ignored", d_out, 64'h0);
        pe_read(2'b00);
        check("rx_stale_data", d_out, 64'hA000_0000_CAFEF00D);
        check("rx_stale_ro", {63'h0, net_ro}, 64'h1);

        // Back-to-back arrivals: second ignored while full
        net_si = 1'b1; net_di = 64'h0000_0000_0000_1111;
        tick();
        net_di = 64'h0000_0000_0000_2222;
        tick();
        net_si = 1'b0;
        check("b2b_ro", {63'h0, net_ro}, 64'h0);
        pe_read(2'b00);
        check("b2b_first", d_out, 64'h0000_0000_0000_1111);
        rx_flit(64'h0000_0000_0000_1234);
        check("b2b_ro_second", {63'h0, net_ro}, 64'h0);
        pe_read(2'b00);
        check("b2b_second", d_out, 64'h0000_0000_0000_1234);

        // Reset mid-traffic
        net_ri = 1'b0;
        pe_write(2'b10, 64'h0000_0000_0000_0055);
        rx_flit(64'h0000_0000_0000_0066);
        net_ri = 1'b1;
        #1;
        check("mid_so_pre", {63'h0, net_so}, 64'h1);
        net_ri = 1'b0;
        #1;
        net_ri = 1'b1;
        reset = 1'b0;
        #1;
        check("mid_so", {63'h0, net_so}, 64'h0);
        check("mid_ro", {63'h0, net_ro}, 64'h1);
        check("mid_d_out", d_out, 64'h0);
        @(negedge clk) reset = 1'b1;
        tick();
        pe_read(2'b01);
        check("mid_in_stat", d_out, 64'h0);
        pe_read(2'b11);
        check("mid_out_stat", d_out, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cardinal_nic.md
Name: cardinal_nic

Overview:
Network interface controller bridging one processing element (PE) to its local cardinal router port.
- Outbound path: the PE writes 64-bit flits into a one-entry output channel buffer. The NIC injects them on net_so/net_ri/net_do, gated by the router's net_polarity.
- Inbound path: flits from the router (net_si/net_ro/net_di) land in a one-entry input channel buffer, which the PE reads through a small memory-mapped register interface.
- One instance per mesh node, on the NIC side of the router's pe_* link.

Parameters:
DATA_W, 64, flit width; bit DATA_W-1 is the VC bit.
ADDR_W, 2, PE register address width.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
addr  in  ADDR_W  PE register select
d_in  in  DATA_W  PE write data
d_out  out  DATA_W  PE read data, registered
nicEn  in  1  PE access enable
nicEnWr  in  1  1=write, 0=read (qualified by nicEn)
net_so  out  1  send strobe to router (drives router pe_si)
net_ri  in  1  router ready to accept (router pe_ri)
net_do  out  DATA_W  flit to router (router pe_di)
net_si  in  1  router send strobe (router pe_so)
net_ro  out  1  NIC ready to accept (router pe_ro)
net_di  in  DATA_W  flit from router (router pe_do)
net_polarity  in  1  router external phase (router pe_polarity)

Behaviour:
- Reset (reset=0, async): both buffers empty, buffer data 0, d_out=0, net_so=0, net_do=0, net_ro=1. Deasserts synchronously with no glitch on outputs.
- Address map:
  - 00: input buffer data, read; clears in_full.
  - 01: input status, read; {zeros, in_full}.
  - 10: output buffer data, write.
  - 11: output status, read; {zeros, out_full}.
- Reads (nicEn=1, nicEnWr=0): d_out loads the selected value on the posedge, so it is valid 1 cycle after the request. d_out holds its value when there is no read.
- Read of addr 00 with in_full=1 clears in_full at that edge. Read of addr 00 when empty returns stale buffer data and changes no state.
- Writes to addr 10 (nicEn=1, nicEnWr=1):
  - If out_full=0 at the edge: capture d_in, set out_full.
  - If out_full=1: write silently dropped. This applies even if a send completes on the same edge; occupancy is sampled before the edge.
- Writes to addr 00/01/11 and reads of addr 10 are ignored; d_out holds.
- Send:
  - net_so = out_full & net_ri & (out_buf[DATA_W-1] == net_polarity), combinational.
  - net_do = out_buf, continuously.
  - On a posedge with net_so=1, out_full clears and the flit is gone.
  - A flit whose VC bit mismatches polarity waits, with no timeout, until polarity toggles.
- Receive:
  - net_ro = ~in_full, combinational.
  - On a posedge with net_si & net_ro: capture net_di, set in_full.
  - net_si while in_full=1 is a router protocol violation; the flit is ignored and the buffer keeps its data.
- Simultaneous events:
  - PE read of 00 and router arrival on the same edge cannot collide, because net_ro=0 while full.
  - A flit arriving one cycle after the read edge is accepted.
- Throughput: max one flit per 2 cycles on each path, since a one-entry buffer needs one cycle to fill and one to drain.

Decomposition:
- Shared package:
  - Address constants ADDR_IN_DATA=2'b00, ADDR_IN_STAT=2'b01, ADDR_OUT_DATA=2'b10, ADDR_OUT_STAT=2'b11.
  - VC_BIT = DATA_W-1, plus header field offsets (Dx 62, Dy 61, Hx 55:52, Hy 51:48, SrcX 47:40, SrcY 39:32).
- Sub-module nic_chan_buf: one-entry register with full flag, load/unload strobes and async active-low reset. Instantiated twice (input and output).

Test Plan:
- Reset mid-traffic: out_full=1 and in_full=1, then assert reset low off-edge -> net_so=0, net_ro=1, d_out=0 immediately; status reads 0 after release.
- Send, polarity match: write 64'h2033_0300_DEADBEEF to addr 10 with net_ri=1, net_polarity=0 -> net_so=1 next cycle with net_do equal to the flit; status 11 reads 0 after the send edge.
- Send, polarity hold: write flit with bit63=1 while polarity=0 for 3 cycles -> net_so stays 0. Polarity goes to 1 -> net_so=1 that cycle, then the buffer empties.
- Output overflow: write A, then write B while net_ri=0 -> status 11 reads 1. On release, net_do sends A; B is lost.
- Receive: net_si=1 with net_di=64'hA000_0000_CAFEF00D -> net_ro=0 next cycle. Status 01 read -> d_out=1. Read 00 -> d_out=64'hA000_0000_CAFEF00D one cycle later; net_ro=1 after that edge.
- Back-to-back: router asserts net_si on consecutive cycles -> only the first is accepted while net_ro=0. After the PE read, a second flit 64'h...1234 is accepted and read correctly.
